// File: rtl/execute_out_buffer.sv
// ---------------------------------------------------------------------------
// execute_out_buffer
//
// Purpose: small first-word-fall-through FIFO that captures the execute
// stage result bundle (instruction, ALU result, PC, memory data, control
// and register fields) and hands it to the next stage with a valid/ready
// handshake. Captures arriving while the buffer is full and no entry is
// leaving are dropped, and a sticky overflow flag records the loss.
//
// Optional feature: define EXECUTE_OUT_BUFFER_DROP_CNT_EN to add an 8-bit
// saturating drop_count output. It counts dropped captures and clears on
// reset or flush.
//
// Parameters:
//   DATA_W : width of IR_exec, aluout, pcout and M_data
//   REG_W  : width of sr1, sr2 and dr
//   DEPTH  : number of entries, a power of two and at least 2
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   enable_execute        capture request from the execute stage
//   IR_exec .. NZP        field bundle to capture
//   flush                 synchronous discard of all entries
//   out_ready             downstream accepts the head entry
//   out_valid             head entry present (equals !empty)
//   out_*                 head entry fields, all zero while empty
//   count, full, empty    occupancy
//   overflow              sticky flag, set when a capture is dropped
//   drop_count            dropped-capture count (macro builds only)
// ---------------------------------------------------------------------------
module execute_out_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable_execute,
    input  logic [DATA_W-1:0]            IR_exec,
    input  logic [DATA_W-1:0]            aluout,
    input  logic [DATA_W-1:0]            pcout,
    input  logic [DATA_W-1:0]            M_data,
    input  logic [1:0]                   W_control_out,
    input  logic                         Mem_control_out,
    input  logic [REG_W-1:0]             sr1,
    input  logic [REG_W-1:0]             sr2,
    input  logic [REG_W-1:0]             dr,
    input  logic [2:0]                   NZP,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_IR_exec,
    output logic [DATA_W-1:0]            out_aluout,
    output logic [DATA_W-1:0]            out_pcout,
    output logic [DATA_W-1:0]            out_M_data,
    output logic [1:0]                   out_W_control_out,
    output logic                         out_Mem_control_out,
    output logic [REG_W-1:0]             out_sr1,
    output logic [REG_W-1:0]             out_sr2,
    output logic [REG_W-1:0]             out_dr,
    output logic [2:0]                   out_NZP,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] ir_exec;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] pcout;
        logic [DATA_W-1:0] m_data;
        logic [1:0]        w_control;
        logic              mem_control;
        logic [REG_W-1:0]  sr1;
        logic [REG_W-1:0]  sr2;
        logic [REG_W-1:0]  dr;
        logic [2:0]        nzp;
    } entry_t;

    // Storage is not reset: pointers and count alone define what is valid.
    entry_t              mem_q [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic                overflow_q, overflow_d;

    logic                push;
    logic                pop;
    logic                drop;
    entry_t              wr_entry;
    entry_t              head_entry;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Flush wins over both handshakes; a pop frees a slot for a push in
    // the same cycle, so a full buffer can still accept while draining.
    assign pop  = out_valid && out_ready && !flush;
    assign push = enable_execute && !flush && (!full || pop);
    assign drop = enable_execute && !flush && full && !pop;

    always_comb begin
        wr_entry             = '0;
        wr_entry.ir_exec     = IR_exec;
        wr_entry.aluout      = aluout;
        wr_entry.pcout       = pcout;
        wr_entry.m_data      = M_data;
        wr_entry.w_control   = W_control_out;
        wr_entry.mem_control = Mem_control_out;
        wr_entry.sr1         = sr1;
        wr_entry.sr2         = sr2;
        wr_entry.dr          = dr;
        wr_entry.nzp         = NZP;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head entry falls through combinationally; masked to zero while empty
    // so stale storage never appears on the outputs.
    always_comb begin
        head_entry = '0;
        if (out_valid) begin
            head_entry = mem_q[rd_ptr_q];
        end
    end

    assign out_IR_exec         = head_entry.ir_exec;
    assign out_aluout          = head_entry.aluout;
    assign out_pcout           = head_entry.pcout;
    assign out_M_data          = head_entry.m_data;
    assign out_W_control_out   = head_entry.w_control;
    assign out_Mem_control_out = head_entry.mem_control;
    assign out_sr1             = head_entry.sr1;
    assign out_sr2             = head_entry.sr2;
    assign out_dr              = head_entry.dr;
    assign out_NZP             = head_entry.nzp;

`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (flush) begin
            drop_count_d = '0;
        end else if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_execute_out_buffer.sv
module tb_execute_out_buffer;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int DEPTH  = 4;

    logic              clock;
    logic              reset;
    logic              enable_execute;
    logic [DATA_W-1:0] IR_exec, aluout, pcout, M_data;
    logic [1:0]        W_control_out;
    logic              Mem_control_out;
    logic [REG_W-1:0]  sr1, sr2, dr;
    logic [2:0]        NZP;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_IR_exec, out_aluout, out_pcout, out_M_data;
    logic [1:0]        out_W_control_out;
    logic              out_Mem_control_out;
    logic [REG_W-1:0]  out_sr1, out_sr2, out_dr;
    logic [2:0]        out_NZP;
    logic [$clog2(DEPTH):0] count;
    logic              full, empty, overflow;
`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    int checks = 0;
    int errors = 0;

    execute_out_buffer #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable_execute      (enable_execute),
        .IR_exec             (IR_exec),
        .aluout              (aluout),
        .pcout               (pcout),
        .M_data              (M_data),
        .W_control_out       (W_control_out),
        .Mem_control_out     (Mem_control_out),
        .sr1                 (sr1),
        .sr2                 (sr2),
        .dr                  (dr),
        .NZP                 (NZP),
        .flush               (flush),
        .out_ready           (out_ready),
        .out_valid           (out_valid),
        .out_IR_exec         (out_IR_exec),
        .out_aluout          (out_aluout),
        .out_pcout           (out_pcout),
        .out_M_data          (out_M_data),
        .out_W_control_out   (out_W_control_out),
        .out_Mem_control_out (out_Mem_control_out),
        .out_sr1             (out_sr1),
        .out_sr2             (out_sr2),
        .out_dr              (out_dr),
        .out_NZP             (out_NZP),
        .count               (count),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow)
`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
        ,
        .drop_count          (drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable_execute = 1'b0; flush = 1'b0; out_ready = 1'b0;
        IR_exec = '0; aluout = '0; pcout = '0; M_data = '0;
        W_control_out = '0; Mem_control_out = 1'b0;
        sr1 = '0; sr2 = '0; dr = '0; NZP = '0;

        // Reset state
        #1;
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_full",   32'(full), 32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_count",  32'(count), 32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);
        check("rst_alu",    32'(out_aluout), 32'd0);
        // A capture request while reset is held is ignored
        enable_execute = 1'b1; aluout = 16'hDEAD;
        step();
        check("rst_hold_count", 32'(count), 32'd0);
        enable_execute = 1'b0;
        #2 reset = 1'b0;

        // Single capture, all fields, first edge after reset release
        enable_execute = 1'b1; aluout = 16'h1234; IR_exec = 16'h1042;
        pcout = 16'h0101; M_data = 16'hBEEF; W_control_out = 2'b10;
        Mem_control_out = 1'b1; sr1 = 3'd3; sr2 = 3'd5; dr = 3'd6; NZP = 3'b010;
        step();
        enable_execute = 1'b0;
        check("cap_valid", 32'(out_valid), 32'd1);
        check("cap_alu",   32'(out_aluout), 32'h1234);
        check("cap_ir",    32'(out_IR_exec), 32'h1042);
        check("cap_pc",    32'(out_pcout), 32'h0101);
        check("cap_mdata", 32'(out_M_data), 32'hBEEF);
        check("cap_wctl",  32'(out_W_control_out), 32'h2);
        check("cap_mctl",  32'(out_Mem_control_out), 32'h1);
        check("cap_sr1",   32'(out_sr1), 32'd3);
        check("cap_sr2",   32'(out_sr2), 32'd5);
        check("cap_dr",    32'(out_dr), 32'd6);
        check("cap_nzp",   32'(out_NZP), 32'h2);
        check("cap_count", 32'(count), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cap_flush_count", 32'(count), 32'd0);

        // Full boundary: 5 pushes with no pops
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enable_execute = 1'b1; pcout = 16'h2000 + 16'(i);
            step();
            if (i == 3) begin
                check("full_flag4", 32'(full), 32'd1);
                check("full_count4", 32'(count), 32'd4);
                check("full_ovf4", 32'(overflow), 32'd0);
            end
        end
        enable_execute = 1'b0;
        check("drop_count_hold", 32'(count), 32'd4);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_head", 32'(out_pcout), 32'h2000);
`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
        check("drop_cnt", 32'(drop_count), 32'd1);
`endif

        // Full with simultaneous push and pop
        enable_execute = 1'b1; out_ready = 1'b1; pcout = 16'h2010;
        step();
        enable_execute = 1'b0;
        check("pp_count", 32'(count), 32'd4);
        check("pp_head",  32'(out_pcout), 32'h2001);
        check("pp_ovf",   32'(overflow), 32'd1);
        // Drain and confirm the appended entry is last
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_pc;
            exp_pc = (i == 3) ? 16'h2010 : 16'h2001 + 16'(i);
            check("drain_pc", 32'(out_pcout), 32'(exp_pc));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_zero",  32'(out_pcout), 32'd0);

        // Flush versus push with count=3 (overflow still set from before)
        for (int i = 0; i < 3; i++) begin
            enable_execute = 1'b1; pcout = 16'h4000 + 16'(i);
            step();
        end
        check("fl_pre_count", 32'(count), 32'd3);
        flush = 1'b1; enable_execute = 1'b1; out_ready = 1'b1; pcout = 16'h4444;
        step();
        flush = 1'b0; enable_execute = 1'b0; out_ready = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_ovf",   32'(overflow), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_pc",    32'(out_pcout), 32'd0);
`ifdef EXECUTE_OUT_BUFFER_DROP_CNT_EN
        check("fl_drop_cnt", 32'(drop_count), 32'd0);
`endif

        // Order and wrap with continuous popping
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enable_execute = 1'b1; pcout = 16'h3000 + 16'(i);
            step();
            check("wrap_pc", 32'(out_pcout), 32'(16'h3000 + 16'(i)));
            check("wrap_count", 32'(count), 32'd1);
        end
        enable_execute = 1'b0;
        step();
        check("wrap_empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // Asynchronous reset between edges
        for (int i = 0; i < 2; i++) begin
            enable_execute = 1'b1; pcout = 16'h5000 + 16'(i);
            step();
        end
        enable_execute = 1'b0;
        check("ar_pre_count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_pc",    32'(out_pcout), 32'd0);
        #1 reset = 1'b0;
        enable_execute = 1'b1; pcout = 16'h6000;
        step();
        enable_execute = 1'b0;
        check("ar_push_count", 32'(count), 32'd1);
        check("ar_push_pc",    32'(out_pcout), 32'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
